// File: rtl/fft_mag_stage.sv
// Power-spectrum stage: reads the first N/2 FFT bins, writes squared magnitudes
// to the display buffer in natural order and reports the strongest bin per frame.
module fft_mag_stage #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned N_POINTS    = 1024,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter bit          BITREV_IN   = 1'b0,
    parameter bit          SKIP_DC     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fft_done_i,
    output logic [ADDR_WIDTH-1:0]        fft_addr_o,
    input  logic signed [DATA_WIDTH-1:0] fft_re_i,
    input  logic signed [DATA_WIDTH-1:0] fft_im_i,
    output logic [ADDR_WIDTH-2:0]        mag_addr_o,
    output logic [OUT_WIDTH-1:0]         mag_data_o,
    output logic                         mag_we_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic [ADDR_WIDTH-2:0]        peak_bin_o,
    output logic [OUT_WIDTH-1:0]         peak_mag_o,
    output logic                         overrun_o
);

    localparam int unsigned HALF   = N_POINTS / 2;
    localparam int unsigned BIN_W  = ADDR_WIDTH - 1;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    // valid/tag stages from address issue up to the products register
    localparam int unsigned VDEPTH = RAM_LATENCY + 3;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   k_cnt, k_cnt_n;
    logic [ADDR_WIDTH-1:0]   fft_addr_n;
    logic                    issue_c;
    logic [BIN_W-1:0]        issue_tag_c;
    logic                    frame_start_c;
    logic                    frame_done_n;
    logic                    busy_n;
    logic                    overrun_n;

    logic [VDEPTH-1:0]       v_sr;
    logic [BIN_W-1:0]        tag_sr [VDEPTH];
    logic signed [DATA_WIDTH-1:0] re_r, im_r;
    logic signed [PROD_W-1:0]     sq_re, sq_im;
    logic [PROD_W-1:0]       pwr_c;
    logic [OUT_WIDTH-1:0]    scaled_c;
    logic                    cand_c;

    logic [OUT_WIDTH-1:0]    run_max;
    logic [BIN_W-1:0]        run_bin;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] k);
        logic [ADDR_WIDTH-1:0] r;
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = k[ADDR_WIDTH-1-i];
        end
        return BITREV_IN ? r : k;
    endfunction

    // Next-state, address issue and status flags
    always_comb begin
        state_n       = state;
        k_cnt_n       = k_cnt;
        fft_addr_n    = fft_addr_o;
        issue_c       = 1'b0;
        issue_tag_c   = '0;
        frame_start_c = 1'b0;
        frame_done_n  = 1'b0;
        overrun_n     = overrun_o;
        case (state)
            IDLE: begin
                if (fft_done_i) begin
                    state_n       = READ;
                    frame_start_c = 1'b1;
                    issue_c       = 1'b1;
                    fft_addr_n    = addr_of('0);
                    k_cnt_n       = ADDR_WIDTH'(1);
                end
            end
            READ: begin
                if (fft_done_i) overrun_n = 1'b1;
                if (k_cnt == ADDR_WIDTH'(HALF)) begin
                    state_n = DRAIN;
                end else begin
                    issue_c     = 1'b1;
                    issue_tag_c = BIN_W'(k_cnt);
                    fft_addr_n  = addr_of(k_cnt);
                    k_cnt_n     = k_cnt + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (fft_done_i) overrun_n = 1'b1;
                if (v_sr == '0) begin
                    state_n      = DONE;
                    frame_done_n = 1'b1;
                end
            end
            DONE: begin
                if (fft_done_i) overrun_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // FSM state and control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_cnt        <= '0;
            fft_addr_o   <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            state        <= state_n;
            k_cnt        <= k_cnt_n;
            fft_addr_o   <= fft_addr_n;
            busy_o       <= busy_n;
            frame_done_o <= frame_done_n;
            overrun_o    <= overrun_n;
        end
    end

    // Power of the bin currently in the products stage, top bits kept
    always_comb begin
        pwr_c    = PROD_W'($unsigned(sq_re)) + PROD_W'($unsigned(sq_im));
        scaled_c = pwr_c[PROD_W-1 -: OUT_WIDTH];
        cand_c   = v_sr[VDEPTH-1] && !(SKIP_DC && (tag_sr[VDEPTH-1] == '0));
    end

    // Data path: valid/tag shift, re/im capture, squares, buffer write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_sr       <= '0;
            for (int unsigned i = 0; i < VDEPTH; i++) tag_sr[i] <= '0;
            re_r       <= '0;
            im_r       <= '0;
            sq_re      <= '0;
            sq_im      <= '0;
            mag_we_o   <= 1'b0;
            mag_addr_o <= '0;
            mag_data_o <= '0;
        end else begin
            v_sr      <= {v_sr[VDEPTH-2:0], issue_c};
            tag_sr[0] <= issue_tag_c;
            for (int unsigned i = 1; i < VDEPTH; i++) tag_sr[i] <= tag_sr[i-1];
            re_r       <= fft_re_i;
            im_r       <= fft_im_i;
            sq_re      <= PROD_W'(re_r) * PROD_W'(re_r);
            sq_im      <= PROD_W'(im_r) * PROD_W'(im_r);
            mag_we_o   <= v_sr[VDEPTH-1];
            mag_addr_o <= tag_sr[VDEPTH-1];
            mag_data_o <= scaled_c;
        end
    end

    // Running peak search; strict compare keeps the lowest index on ties
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_max    <= '0;
            run_bin    <= '0;
            peak_bin_o <= '0;
            peak_mag_o <= '0;
        end else begin
            if (frame_start_c) begin
                run_max <= '0;
                run_bin <= SKIP_DC ? BIN_W'(1) : '0;
            end else if (cand_c && (scaled_c > run_max)) begin
                run_max <= scaled_c;
                run_bin <= tag_sr[VDEPTH-1];
            end
            if (frame_done_n) begin
                peak_bin_o <= run_bin;
                peak_mag_o <= run_max;
            end
        end
    end

endmodule
